// File: rtl/shader_instr_fetcher_if.sv
// Bundle of the fetcher's control, memory-request/response and instruction-stream signals.
// The checksum pair exists only when SHADER_FETCH_CHKSUM_EN is defined.
interface shader_instr_fetcher_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 12
);
    logic              start;
    logic [ADDR_W-1:0] prog_base;
    logic [LEN_W-1:0]  prog_len;
    logic              busy;
    logic              done;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [3:0]        mem_req_beats;
    logic              mem_rsp_valid;
    logic [127:0]      mem_rsp_data;
    logic              mem_rsp_ready;
    logic              instr_valid;
    logic [31:0]       instr;
    logic              instr_ready;
`ifdef SHADER_FETCH_CHKSUM_EN
    logic [31:0]       chk_expected;
    logic              chk_err;

    modport master (
        input  start, prog_base, prog_len, mem_req_ready, mem_rsp_valid, mem_rsp_data,
               instr_ready, chk_expected,
        output busy, done, mem_req_valid, mem_req_addr, mem_req_beats, mem_rsp_ready,
               instr_valid, instr, chk_err
    );
    modport slave (
        output start, prog_base, prog_len, mem_req_ready, mem_rsp_valid, mem_rsp_data,
               instr_ready, chk_expected,
        input  busy, done, mem_req_valid, mem_req_addr, mem_req_beats, mem_rsp_ready,
               instr_valid, instr, chk_err
    );
`else
    modport master (
        input  start, prog_base, prog_len, mem_req_ready, mem_rsp_valid, mem_rsp_data,
               instr_ready,
        output busy, done, mem_req_valid, mem_req_addr, mem_req_beats, mem_rsp_ready,
               instr_valid, instr
    );
    modport slave (
        output start, prog_base, prog_len, mem_req_ready, mem_rsp_valid, mem_rsp_data,
               instr_ready,
        input  busy, done, mem_req_valid, mem_req_addr, mem_req_beats, mem_rsp_ready,
               instr_valid, instr
    );
`endif
endinterface

// File: rtl/shader_instr_fetcher.sv
// Burst-reads a shader program in 128-bit beats, unpacks four instructions per beat into a FIFO
// and streams them out. Define SHADER_FETCH_CHKSUM_EN to add the popped-instruction XOR check.
module shader_instr_fetcher #(
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    shader_instr_fetcher_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CMP_W = (CNT_W > 6) ? CNT_W : 6;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_RECV  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_beats_left;
    logic [LEN_W-1:0]  r_instr_left;
    logic [3:0]        r_beat_cnt;
    logic              r_done;
    logic [31:0]       r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic [LEN_W:0]    w_len_plus3;
    logic [LEN_W-1:0]  w_len_beats;
    logic [3:0]        w_burst;
    logic [CMP_W-1:0]  w_free;
    logic [CMP_W-1:0]  w_need;
    logic              w_space_ok;
    logic              w_req_fire;
    logic              w_rsp_fire;
    logic              w_pop;
    logic [2:0]        w_push_n;
    logic [2:0]        w_push_cnt;

    assign w_len_plus3 = {1'b0, bus.prog_len} + (LEN_W+1)'(2'd3);
    assign w_len_beats = {1'b0, w_len_plus3[LEN_W:2]};
    assign w_burst     = (r_beats_left >= LEN_W'(MAX_BURST)) ? 4'(MAX_BURST) : r_beats_left[3:0];

    // A request is only issued once the whole burst is guaranteed a home in the FIFO,
    // which is what lets RECV accept every beat unconditionally.
    assign w_free     = CMP_W'(CNT_W'(FIFO_DEPTH) - r_count);
    assign w_need     = CMP_W'({w_burst, 2'b00});
    assign w_space_ok = (w_free >= w_need);

    assign w_req_fire = (r_state == S_REQ) && w_space_ok && bus.mem_req_ready;
    assign w_rsp_fire = (r_state == S_RECV) && bus.mem_rsp_valid;
    assign w_pop      = (r_count != {CNT_W{1'b0}}) && bus.instr_ready;
    assign w_push_n   = (r_instr_left >= LEN_W'(3'd4)) ? 3'd4 : r_instr_left[2:0];
    assign w_push_cnt = w_rsp_fire ? w_push_n : 3'd0;

    assign bus.busy          = (r_state != S_IDLE);
    assign bus.done          = r_done;
    assign bus.mem_req_valid = (r_state == S_REQ) && w_space_ok;
    assign bus.mem_req_addr  = r_addr;
    assign bus.mem_req_beats = (r_state == S_REQ) ? w_burst : 4'd0;
    assign bus.mem_rsp_ready = (r_state == S_RECV);
    assign bus.instr_valid   = (r_count != {CNT_W{1'b0}});
    assign bus.instr         = bus.instr_valid ? r_fifo[r_rd_ptr] : 32'd0;

    // Control FSM: program latch, burst issue, beat accounting and the done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_addr       <= {ADDR_W{1'b0}};
            r_beats_left <= {LEN_W{1'b0}};
            r_instr_left <= {LEN_W{1'b0}};
            r_beat_cnt   <= 4'd0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_addr       <= bus.prog_base & ~ADDR_W'(4'hF);
                        r_beats_left <= w_len_beats;
                        r_instr_left <= bus.prog_len;
                        r_state      <= (bus.prog_len == {LEN_W{1'b0}}) ? S_DRAIN : S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_req_fire) begin
                        r_addr       <= r_addr + ADDR_W'({w_burst, 4'b0000});
                        r_beats_left <= r_beats_left - LEN_W'(w_burst);
                        r_beat_cnt   <= w_burst;
                        r_state      <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (w_rsp_fire) begin
                        r_instr_left <= r_instr_left - LEN_W'(w_push_n);
                        r_beat_cnt   <= r_beat_cnt - 4'd1;
                        if (r_beat_cnt == 4'd1) begin
                            r_state <= (r_beats_left != {LEN_W{1'b0}}) ? S_REQ : S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_count == {CNT_W{1'b0}}) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; push and pop in one cycle are both honoured
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_cnt);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
            r_count  <= r_count + CNT_W'(w_push_cnt) - CNT_W'(w_pop);
        end
    end

    // FIFO storage: word k of the beat lands k slots after the write pointer
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < w_push_cnt) begin
                r_fifo[r_wr_ptr + PTR_W'(k)] <= bus.mem_rsp_data[32*k +: 32];
            end
        end
    end

`ifdef SHADER_FETCH_CHKSUM_EN
    logic [31:0] r_xor;
    logic [31:0] r_chk_exp;
    logic        r_chk_err;

    assign bus.chk_err = r_chk_err;

    // Running XOR of consumed instructions, compared when done fires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xor     <= 32'd0;
            r_chk_exp <= 32'd0;
            r_chk_err <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && bus.start) begin
                r_xor     <= 32'd0;
                r_chk_exp <= bus.chk_expected;
            end else if (w_pop) begin
                r_xor <= r_xor ^ bus.instr;
            end
            if ((r_state == S_DRAIN) && (r_count == {CNT_W{1'b0}})) begin
                r_chk_err <= (r_xor != r_chk_exp);
            end
        end
    end
`endif
endmodule

// File: tb/tb_shader_instr_fetcher.sv
// Randomized bench for shader_instr_fetcher: a memory model answers bursts from an address hash and
// a queue-based program model predicts requests, instruction order, done and (optionally) chk_err.
module tb_shader_instr_fetcher;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    shader_instr_fetcher_if #(.ADDR_W(32), .LEN_W(12)) bus ();

    shader_instr_fetcher #(.ADDR_W(32), .LEN_W(12), .FIFO_DEPTH(16), .MAX_BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int p_req = 100;
    int p_rsp = 100;
    int p_ir  = 100;
    int done_cnt   = 0;
    int req_hs_cnt = 0;
    int rsp_hs_cnt = 0;
    logic [31:0] exp_xor;
    logic [31:0] exp_instr[$];
    logic [31:0] exp_addr[$];
    logic [3:0]  exp_beats[$];
    logic [31:0] rsp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] m;
        m = a * 32'h9E37_79B1;
        return m ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [127:0] beat_data(input logic [31:0] a);
        return {mem_word(a + 32'd12), mem_word(a + 32'd8), mem_word(a + 32'd4), mem_word(a)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive memory/downstream inputs, score the handshakes they cause, advance
    task automatic cycle();
        bus.mem_req_ready = ($urandom_range(99) < p_req);
        if (rsp_q.size() > 0 && $urandom_range(99) < p_rsp) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = beat_data(rsp_q[0]);
        end else begin
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
        end
        bus.instr_ready = ($urandom_range(99) < p_ir);
        if (bus.mem_req_valid && bus.mem_req_ready) begin
            req_hs_cnt++;
            if (exp_addr.size() == 0) begin
                check("req_extra", 64'(exp_addr.size()), 64'd1);
            end else begin
                check("req_addr", bus.mem_req_addr, exp_addr.pop_front());
                check("req_beats", bus.mem_req_beats, exp_beats.pop_front());
                for (int b = 0; b < int'(bus.mem_req_beats); b++)
                    rsp_q.push_back(bus.mem_req_addr + 32'(16 * b));
            end
        end
        if (bus.mem_rsp_valid && bus.mem_rsp_ready) begin
            rsp_hs_cnt++;
            void'(rsp_q.pop_front());
        end
        if (bus.instr_valid && bus.instr_ready) begin
            if (exp_instr.size() == 0) check("instr_extra", 64'(exp_instr.size()), 64'd1);
            else check("instr", bus.instr, exp_instr.pop_front());
        end
        if (bus.done) done_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [31:0] base, input int len, input logic flip);
        logic [31:0] a;
        logic [31:0] w;
        int beats;
        int b;
        a = base & ~32'hF;
        exp_xor = 32'd0;
        for (int i = 0; i < len; i++) begin
            w = mem_word(a + 32'(4 * i));
            exp_instr.push_back(w);
            exp_xor ^= w;
        end
        beats = (len + 3) / 4;
        while (beats > 0) begin
            b = (beats > 4) ? 4 : beats;
            exp_addr.push_back(a);
            exp_beats.push_back(4'(b));
            a += 32'(16 * b);
            beats -= b;
        end
        bus.prog_base = base;
        bus.prog_len  = 12'(len);
`ifdef SHADER_FETCH_CHKSUM_EN
        bus.chk_expected = exp_xor ^ (flip ? 32'h0000_0100 : 32'h0000_0000);
`else
        if (flip) exp_xor = ~exp_xor;
`endif
        bus.start  = 1'b1;
        done_cnt   = 0;
        req_hs_cnt = 0;
        cycle();
        bus.start = 1'b0;
    endtask

    task automatic finish_prog(input logic flip);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 4000) begin
            cycle();
            n++;
        end
        check("done_seen", done_cnt, 1);
        check("busy_after_done", bus.busy, 1'b0);
        check("instr_left", exp_instr.size(), 0);
        check("req_left", exp_addr.size(), 0);
`ifdef SHADER_FETCH_CHKSUM_EN
        check("chk_err", bus.chk_err, flip);
`endif
        cycle();
        cycle();
        check("done_single", done_cnt, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_done"}, bus.done, 1'b0);
        check({tag, "_req_valid"}, bus.mem_req_valid, 1'b0);
        check({tag, "_rsp_ready"}, bus.mem_rsp_ready, 1'b0);
        check({tag, "_instr_valid"}, bus.instr_valid, 1'b0);
        check({tag, "_req_addr"}, bus.mem_req_addr, 32'd0);
        check({tag, "_req_beats"}, bus.mem_req_beats, 4'd0);
        check({tag, "_instr"}, bus.instr, 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.prog_base = 32'd0;
        bus.prog_len = 12'd0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data = 128'd0;
        bus.instr_ready = 1'b0;
`ifdef SHADER_FETCH_CHKSUM_EN
        bus.chk_expected = 32'd0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
`ifdef SHADER_FETCH_CHKSUM_EN
        check("reset_chk_err", bus.chk_err, 1'b0);
`endif
        rst_n = 1'b1;
        cycle();

        // Basic: one 2-beat request, request visible the cycle after start
        launch(32'h0000_1000, 8, 1'b0);
        check("req_latency", bus.mem_req_valid, 1'b1);
        check("req_addr_first", bus.mem_req_addr, 32'h0000_1000);
        check("req_beats_first", bus.mem_req_beats, 4'd2);
        finish_prog(1'b0);

        // Partial last beat: three padding words must be dropped
        launch(32'h0000_2008, 5, 1'b0);
        finish_prog(1'b0);

        // Zero length: done exactly two cycles after start, never a request
        launch(32'h0000_3000, 0, 1'b0);
        check("zero_done_n1", bus.done, 1'b0);
        check("zero_req_n1", bus.mem_req_valid, 1'b0);
        cycle();
        check("zero_done_n2", bus.done, 1'b1);
        check("zero_req_n2", bus.mem_req_valid, 1'b0);
        finish_prog(1'b0);

        // Backpressure: FIFO fills with one 4-beat burst, then requests stop
        p_ir = 0;
        launch(32'h0001_0000, 40, 1'b0);
        repeat (40) cycle();
        check("bp_req_count", req_hs_cnt, 1);
        check("bp_req_valid", bus.mem_req_valid, 1'b0);
        check("bp_instr_valid", bus.instr_valid, 1'b1);
        check("bp_head", bus.instr, exp_instr[0]);
        p_ir = 100;
        finish_prog(1'b0);

        // Start while busy: second start during RECV is ignored
        p_rsp = 50;
        launch(32'h0002_0000, 24, 1'b0);
        n = 0;
        while (!bus.mem_rsp_ready && n < 200) begin
            cycle();
            n++;
        end
        check("reached_recv", bus.mem_rsp_ready, 1'b1);
        bus.prog_base = 32'h00AB_CD00;
        bus.prog_len  = 12'd3;
        bus.start     = 1'b1;
        cycle();
        bus.start = 1'b0;
        finish_prog(1'b0);

        // Reset after the first of two beats, then a clean refetch
        p_rsp = 100;
        p_ir  = 0;
        launch(32'h0003_0000, 8, 1'b0);
        rsp_hs_cnt = 0;
        n = 0;
        while (rsp_hs_cnt == 0 && n < 50) begin
            cycle();
            n++;
        end
        check("rst_one_beat", rsp_hs_cnt, 1);
        check("rst_in_recv", bus.mem_rsp_ready, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        check("midrst_next_instr_valid", bus.instr_valid, 1'b0);
        exp_instr.delete();
        exp_addr.delete();
        exp_beats.delete();
        rsp_q.delete();
        bus.mem_rsp_valid = 1'b0;
        rst_n = 1'b1;
        p_ir = 100;
        cycle();
        launch(32'h0004_0000, 8, 1'b0);
        finish_prog(1'b0);
        launch(32'h0004_0000, 8, 1'b1);
        finish_prog(1'b1);

        // Randomized programs, including address wrap near the top of memory
        for (int t = 0; t < 16; t++) begin
            logic [31:0] base;
            logic flip;
            base  = (t % 4 == 3) ? (32'hFFFF_FF00 + 32'($urandom_range(255))) : $urandom;
            flip  = 1'($urandom_range(1));
            p_req = $urandom_range(100, 30);
            p_rsp = $urandom_range(100, 30);
            p_ir  = $urandom_range(100, 10);
            launch(base, $urandom_range(70, 0), flip);
            finish_prog(flip);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
